frame_reader: RTL and testbench
===============================

# frame_reader

Streams a stored 24-bit frame out of byte-addressed image memory as a raster-order pixel stream. It is the read side of the image-processing flow: filters such as crop write a bottom-up, 3-bytes-per-pixel frame buffer, and this block fetches it back top-down and left-to-right. Pixels leave on a valid/ready interface with coordinates and frame markers, so downstream stages see row 0 first.

## Interface
- WIDTH, 768, pixels per row
- HEIGHT, 512, rows per frame
- ADDR_W, 21, byte-address width; must satisfy 2^ADDR_W ≥ WIDTH*HEIGHT*3
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a frame read; sampled only in IDLE
- mem_rd_en  out  1  byte read strobe
- mem_addr  out  ADDR_W  byte address
- mem_rdata  in  8  read data, valid exactly 1 cycle after mem_rd_en
- pix_valid  out  1  pixel present
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  24  {byte2, byte1, byte0} of the pixel
- pix_x  out  16  column, 0..WIDTH-1
- pix_y  out  16  row, 0..HEIGHT-1 (0 = top)
- pix_sof / pix_eol / pix_eof  out  1 each  first pixel of frame / last of row / last of frame
- busy  out  1  high from start accept until done
- done  out  1  one-cycle pulse after the final handshake

## Operation
- Address of byte k (0..2) of pixel (x,y): WIDTH*3*(HEIGHT-1-y) + 3*x + k, computed in ADDR_W bits, no wrap for legal parameters.
- FSM states: IDLE, FETCH0, FETCH1, FETCH2, CAPTURE, OUT.
- IDLE: start=1 → FETCH0, x=y=0, busy=1. start=0 → stay.
- FETCH0: rd_en=1, addr=byte0 → FETCH1.
- FETCH1: rd_en=1, addr=byte1; latch mem_rdata as byte0 → FETCH2.
- FETCH2: rd_en=1, addr=byte2; latch byte1 → CAPTURE.
- CAPTURE: rd_en=0; latch byte2 → OUT.
- OUT: pix_valid=1; pix_data, pix_x, pix_y and the flags are held stable until pix_ready=1.
  - On the handshake, if not the last pixel: x increments, wrapping to 0 with y+1 at x=WIDTH-1 → FETCH0.
  - On the handshake at the last pixel: done=1 for one cycle, busy=0 → IDLE.
- Flags: sof = (x==0 && y==0); eol = (x==WIDTH-1); eof = eol && (y==HEIGHT-1). All are valid only with pix_valid.
- start asserted while busy is ignored. start in the same cycle as done (already IDLE next) is sampled next cycle only.
- mem_rd_en=0 in IDLE, CAPTURE, OUT; mem_addr is don't-care when rd_en=0 and is driven 0.

## Timing
- Reset values: every output 0; state IDLE; x=y=0.
- start accepted at edge k → FETCH0 in cycle k+1. First pix_valid in cycle k+5.
- Per pixel: 4 cycles of fetch/capture plus ≥1 cycle in OUT. Throughput is 1 pixel per 5 cycles when pix_ready is held at 1.
- pix_ready high in cycle t of OUT → next pix_valid at t+5. done pulses in cycle t+1 for the last pixel.
- pix_valid never drops without a handshake. pix_ready while pix_valid=0 has no effect.
- rst mid-frame: next cycle IDLE, all outputs 0, no done pulse, partial frame discarded.

## Structure
- Shared package img_pkg holds:
  - default WIDTH/HEIGHT and BYTES_PER_PIXEL=3;
  - the FSM state enum;
  - a function pixel_byte_addr(x,y,k), also used by writer blocks so both ends agree on layout.
- One sub-module, frame_addr_gen, holds the x/y counters, wrap logic and byte-address computation.
- The top holds the FSM, byte latches and output registers.

## Test plan
- WIDTH=4, HEIGHT=3, model memory byte[a]=a mod 256, pix_ready=1, start pulse at cycle 0:
  - first pixel at cycle 5: x=0, y=0, addresses 24,25,26, data 0x1A1918, sof=1;
  - last pixel: x=3, y=2, data 0x0B0A09, eol=eof=1;
  - done one cycle after the last pixel; 12 pixels total.
- Backpressure: hold pix_ready=0 for 7 cycles at pixel (2,1) → pix_valid and pix_data held constant, no mem_rd_en during the stall, stream resumes at pixel (3,1).
- Row wrap: pixel (3,0) is followed by (0,1) with eol=1 then sof=0; byte0 address of (0,1) is 12.
- start pulsed again mid-frame → ignored, pixel count still 12, one done pulse.
- rst asserted during FETCH1 of pixel (1,1) → all outputs 0 the next cycle, no done. A fresh start then restarts at (0,0) with sof=1.
- Default 768×512: full frame yields 393216 handshakes, first byte address 1177344, final done pulse, busy low afterward.

Source files
------------

// File: rtl/img_pkg.sv
// Shared image-layout definitions for frame readers and writers.
// Frames are stored bottom-up with 3 bytes per pixel.
package img_pkg;

  localparam int unsigned DEF_WIDTH       = 768;
  localparam int unsigned DEF_HEIGHT      = 512;
  localparam int unsigned BYTES_PER_PIXEL = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH0,
    ST_FETCH1,
    ST_FETCH2,
    ST_CAPTURE,
    ST_OUT
  } rd_state_e;

  // Row 0 (top of the image) lives at the highest row offset in memory.
  function automatic logic [31:0] pixel_byte_addr(
    input logic [31:0] x,
    input logic [31:0] y,
    input logic [31:0] k,
    input logic [31:0] width  = DEF_WIDTH,
    input logic [31:0] height = DEF_HEIGHT
  );
    return width * BYTES_PER_PIXEL * (height - 1 - y) + BYTES_PER_PIXEL * x + k;
  endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Raster x/y counters plus byte-address generation for the frame reader.
// The address output refers to the pixel that is current after the coming edge.
module frame_addr_gen
  import img_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance_i,
  input  logic [1:0]        byte_sel_i,
  output logic [15:0]       x_o,
  output logic [15:0]       y_o,
  output logic              last_col_o,
  output logic              last_pix_o,
  output logic [ADDR_W-1:0] byte_addr_o
);

  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic        last_row;

  assign last_col_o = (x_q == 16'(WIDTH - 1));
  assign last_row   = (y_q == 16'(HEIGHT - 1));
  assign last_pix_o = last_col_o && last_row;
  assign x_o        = x_q;
  assign y_o        = y_q;

  // Advancing past the final pixel wraps back to (0,0), so IDLE always sees origin.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (advance_i) begin
      if (last_col_o) begin
        x_d = 16'd0;
        y_d = last_row ? 16'd0 : y_q + 16'd1;
      end else begin
        x_d = x_q + 16'd1;
      end
    end
  end

  assign byte_addr_o = ADDR_W'(pixel_byte_addr(32'(x_d), 32'(y_d), 32'(byte_sel_i),
                                               32'(WIDTH), 32'(HEIGHT)));

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= 16'd0;
      y_q <= 16'd0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

endmodule

// File: rtl/frame_reader.sv
// Reads a bottom-up 24-bit frame from byte memory and emits it top-down
// as a valid/ready pixel stream with coordinates and frame markers.
//   state   | meaning
//   IDLE    | waiting for start
//   FETCH0  | byte0 read issued
//   FETCH1  | byte1 read issued, byte0 captured
//   FETCH2  | byte2 read issued, byte1 captured
//   CAPTURE | byte2 captured into the pixel register
//   OUT     | pixel presented until handshake
module frame_reader
  import img_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT,
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [23:0]       pix_data,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
);

  rd_state_e         state_q;
  logic              rd_en_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        b0_q, b1_q;
  logic [23:0]       data_q;
  logic [15:0]       px_q, py_q;
  logic              valid_q, sof_q, eol_q, eof_q, busy_q, done_q;

  logic              handshake;
  logic [1:0]        byte_sel;
  logic [15:0]       cur_x, cur_y;
  logic              last_col, last_pix;
  logic [ADDR_W-1:0] byte_addr;

  assign handshake = (state_q == ST_OUT) && pix_ready;

  // Select the byte index of the read being issued on the next cycle.
  always_comb begin
    byte_sel = 2'd0;
    case (state_q)
      ST_FETCH0: byte_sel = 2'd1;
      ST_FETCH1: byte_sel = 2'd2;
      default:   byte_sel = 2'd0;
    endcase
  end

  frame_addr_gen #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .advance_i  (handshake),
    .byte_sel_i (byte_sel),
    .x_o        (cur_x),
    .y_o        (cur_y),
    .last_col_o (last_col),
    .last_pix_o (last_pix),
    .byte_addr_o(byte_addr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_en_q <= 1'b0;
      addr_q  <= '0;
      b0_q    <= 8'd0;
      b1_q    <= 8'd0;
      data_q  <= 24'd0;
      px_q    <= 16'd0;
      py_q    <= 16'd0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_FETCH0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            addr_q  <= byte_addr;
          end
        end
        ST_FETCH0: begin
          state_q <= ST_FETCH1;
          addr_q  <= byte_addr;
        end
        ST_FETCH1: begin
          state_q <= ST_FETCH2;
          addr_q  <= byte_addr;
          b0_q    <= mem_rdata;
        end
        ST_FETCH2: begin
          state_q <= ST_CAPTURE;
          rd_en_q <= 1'b0;
          addr_q  <= '0;
          b1_q    <= mem_rdata;
        end
        ST_CAPTURE: begin
          state_q <= ST_OUT;
          data_q  <= {mem_rdata, b1_q, b0_q};
          px_q    <= cur_x;
          py_q    <= cur_y;
          valid_q <= 1'b1;
          sof_q   <= (cur_x == 16'd0) && (cur_y == 16'd0);
          eol_q   <= last_col;
          eof_q   <= last_pix;
        end
        ST_OUT: begin
          if (pix_ready) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            if (last_pix) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_FETCH0;
              rd_en_q <= 1'b1;
              addr_q  <= byte_addr;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign pix_valid = valid_q;
  assign pix_data  = data_q;
  assign pix_x     = px_q;
  assign pix_y     = py_q;
  assign pix_sof   = sof_q;
  assign pix_eol   = eol_q;
  assign pix_eof   = eof_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_frame_reader.sv
// Randomized bench for frame_reader on a 4x3 frame against a raster-order model.
module tb_frame_reader;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int AW     = 6;
  localparam int NPIX   = W * H;
  localparam int MEMSZ  = 1 << AW;

  typedef struct {
    int          x;
    int          y;
    logic [23:0] d;
    int          a;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst, start, pix_ready;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          pix_valid;
  logic [23:0]   pix_data;
  logic [15:0]   pix_x, pix_y;
  logic          pix_sof, pix_eol, pix_eof, busy, done;

  logic [7:0] mem [MEMSZ];
  pix_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  frame_reader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .pix_valid(pix_valid),
    .pix_ready(pix_ready),
    .pix_data (pix_data),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .pix_sof  (pix_sof),
    .pix_eol  (pix_eol),
    .pix_eof  (pix_eof),
    .busy     (busy),
    .done     (done)
  );

  // One-cycle read latency; garbage on idle cycles exposes mistimed captures.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_addr"},  32'(mem_addr), 0);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_data"},  32'(pix_data), 0);
    chk({tag, "_x"},     32'(pix_x), 0);
    chk({tag, "_y"},     32'(pix_y), 0);
    chk({tag, "_flags"}, 32'({pix_sof, pix_eol, pix_eof}), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
  endtask

  task automatic run_frame(input bit rand_mem, input bit rand_ready,
                           input bit start_noise, input int abort_at);
    int          idx, cyc, last_hs, stall_left, a;
    bit          prev_valid, prev_hs, want_done, finished;
    logic [23:0] pd;
    logic [15:0] px, py;
    logic [2:0]  pf;
    int          got_addr[$];
    pix_t        e;

    for (int i = 0; i < MEMSZ; i++) mem[i] = rand_mem ? 8'($urandom) : 8'(i);
    exp_q.delete();
    for (int yy = 0; yy < H; yy++)
      for (int xx = 0; xx < W; xx++) begin
        a = W * 3 * (H - 1 - yy) + 3 * xx;
        exp_q.push_back('{xx, yy, {mem[a+2], mem[a+1], mem[a]}, a});
      end

    idx = 0; last_hs = 0; stall_left = 7;
    prev_valid = 0; prev_hs = 0; want_done = 0; finished = 0;
    pd = '0; px = '0; py = '0; pf = '0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 1;

    while (!finished) begin
      start = (start_noise && !want_done) ? ($urandom_range(0, 3) == 0) : 1'b0;
      if (rand_ready) pix_ready = ($urandom_range(0, 2) != 0);
      else if (pix_valid && idx == 6 && stall_left > 0) begin
        pix_ready = 1'b0;
        stall_left--;
      end else pix_ready = 1'b1;

      if (want_done) begin
        chk("done_pulse", 32'(done), 1);
        chk("busy_after_done", 32'(busy), 0);
        chk("valid_after_done", 32'(pix_valid), 0);
        chk("pix_count", idx, NPIX);
        finished = 1;
      end else begin
        chk("done_early", 32'(done), 0);
        chk("busy", 32'(busy), 1);
        if (mem_rd_en) begin
          chk("rd_while_valid", 32'(pix_valid), 0);
          got_addr.push_back(int'(mem_addr));
        end
        if (pix_valid && !prev_valid) chk("valid_latency", cyc - last_hs, 5);
        if (pix_valid && prev_valid && !prev_hs) begin
          chk("hold_data", 32'(pix_data), 32'(pd));
          chk("hold_xy", {pix_x, pix_y}, {px, py});
          chk("hold_flags", 32'({pix_sof, pix_eol, pix_eof}), 32'(pf));
        end
        if (pix_valid) begin
          pd = pix_data; px = pix_x; py = pix_y; pf = {pix_sof, pix_eol, pix_eof};
        end
        prev_valid = pix_valid;
        prev_hs    = pix_valid && pix_ready;

        if (pix_valid && pix_ready) begin
          e = exp_q[idx];
          chk("pix_x", 32'(pix_x), e.x);
          chk("pix_y", 32'(pix_y), e.y);
          chk("pix_data", 32'(pix_data), 32'(e.d));
          chk("sof", 32'(pix_sof), 32'(e.x == 0 && e.y == 0));
          chk("eol", 32'(pix_eol), 32'(e.x == W - 1));
          chk("eof", 32'(pix_eof), 32'(e.x == W - 1 && e.y == H - 1));
          chk("addr_count", got_addr.size(), 3);
          if (got_addr.size() == 3) begin
            chk("addr_b0", got_addr[0], e.a);
            chk("addr_b1", got_addr[1], e.a + 1);
            chk("addr_b2", got_addr[2], e.a + 2);
          end
          if (!rand_mem && idx == 0) begin
            chk("first_data", 32'(pix_data), 32'h1A1918);
            if (got_addr.size() == 3) chk("first_addr", got_addr[0], 24);
          end
          if (!rand_mem && idx == NPIX - 1) chk("last_data", 32'(pix_data), 32'h0B0A09);
          got_addr.delete();
          idx++;
          last_hs = cyc;
          if (idx == NPIX) want_done = 1;
        end

        if (abort_at >= 0 && idx == abort_at && cyc == last_hs + 2) begin
          chk("abort_in_fetch", 32'(mem_rd_en), 1);
          chk("abort_fetch1_addr", 32'(mem_addr), exp_q[idx].a + 1);
          rst = 1'b1;
          @(negedge clk);
          rst = 1'b0; start = 1'b0;
          chk_idle_outputs("abort");
          for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 0);
            chk("abort_no_busy", 32'(busy), 0);
          end
          finished = 1;
        end

        if (!finished && cyc > 500) begin
          chk("timeout_pix_count", idx, NPIX);
          finished = 1;
        end
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    pix_ready = 1'b0;
    @(negedge clk);
    chk("done_single", 32'(done), 0);
    chk("idle_valid", 32'(pix_valid), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pix_ready = 1'b0;
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'(i);
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("idle_no_busy", 32'(busy), 0);

    run_frame(1'b0, 1'b0, 1'b0, -1);
    run_frame(1'b1, 1'b1, 1'b1, -1);
    run_frame(1'b1, 1'b1, 1'b0, 5);
    run_frame(1'b0, 1'b1, 1'b1, -1);
    for (int f = 0; f < 4; f++) run_frame(1'b1, 1'b1, 1'b1, -1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
